// File: rtl/muldiv_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq_pkg
// Description : Shared definitions for the RV32M multiply/divide sequencer:
//               operation codes (RISC-V funct3 order), FSM state encodings,
//               iteration count and small operation-class helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_seq_pkg;

    localparam int MD_STEPS = 32;

    typedef enum logic [2:0] {
        MDOP_MUL    = 3'd0,
        MDOP_MULH   = 3'd1,
        MDOP_MULHSU = 3'd2,
        MDOP_MULHU  = 3'd3,
        MDOP_DIV    = 3'd4,
        MDOP_DIVU   = 3'd5,
        MDOP_REM    = 3'd6,
        MDOP_REMU   = 3'd7
    } md_op_e;

    typedef enum logic [1:0] {
        MDS_IDLE = 2'd0,
        MDS_CALC = 2'd1,
        MDS_FIX  = 2'd2,
        MDS_DONE = 2'd3
    } md_state_e;

    // Operand A is treated as signed for these ops.
    function automatic logic md_a_signed(input md_op_e op);
        return (op == MDOP_MULH) || (op == MDOP_MULHSU) ||
               (op == MDOP_DIV)  || (op == MDOP_REM);
    endfunction

    // Operand B is treated as signed for these ops (mulhsu keeps B unsigned).
    function automatic logic md_b_signed(input md_op_e op);
        return (op == MDOP_MULH) || (op == MDOP_DIV) || (op == MDOP_REM);
    endfunction

endpackage : muldiv_seq_pkg
`default_nettype wire

// File: rtl/md_addsub.sv
`default_nettype none
// ============================================================================
// Module      : md_addsub
// Description : One add/subtract step shared by the multiply accumulate and
//               the divide trial subtraction.
// Ports       : a, b  - W-bit operands
//               sub   - 1: a - b (two's complement), 0: a + b
//               sum   - W-bit result
//               carry - carry out; on subtract, 1 means a >= b (no borrow)
// Revision    : 1.0 - initial release
// ============================================================================
module md_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum,
    output logic         carry
);

    logic [W-1:0] w_b_eff;
    logic [W:0]   w_total;

    assign w_b_eff = sub ? ~b : b;
    assign w_total = {1'b0, a} + {1'b0, w_b_eff} + {{W{1'b0}}, sub};
    assign sum     = w_total[W-1:0];
    assign carry   = w_total[W];

endmodule : md_addsub
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_seq
// Description : Multi-cycle RV32M multiply/divide sequencer. Iterative
//               shift-add multiply and restoring divide, 32 steps each, with
//               sign correction and result select in a final FIX cycle.
// Ports       : clk, rstn          - clock, asynchronous active-low reset
//               start, op, A, B    - request (sampled in IDLE/DONE only)
//               flush              - synchronous abort, wins over start
//               busy               - high in CALC and FIX
//               done               - one-cycle result-valid pulse
//               result             - held until the next completed op
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] A,
    input  logic [XLEN-1:0] B,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    md_state_e       r_state;
    md_state_e       w_state_nxt;
    logic [5:0]      r_cnt;
    md_op_e          r_op;
    logic            r_sign;
    logic [XLEN-1:0] r_opd;     // multiplicand (mul) or divisor (div) magnitude
    logic [XLEN-1:0] r_hi;      // product high word / partial remainder
    logic [XLEN-1:0] r_lo;      // product low word + multiplier / quotient
    logic [XLEN-1:0] r_result;

    // ---------------- accept-time decode ----------------
    md_op_e          w_op;
    logic            w_accept_st;
    logic            w_accept;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_sign_nxt;
    logic            w_div_zero;
    logic            w_overflow;
    logic            w_special;

    assign w_op        = md_op_e'(op);
    assign w_accept_st = (r_state == MDS_IDLE) || (r_state == MDS_DONE);
    assign w_accept    = w_accept_st && start && !flush;
    assign w_a_neg     = md_a_signed(w_op) && A[XLEN-1];
    assign w_b_neg     = md_b_signed(w_op) && B[XLEN-1];
    assign w_a_mag     = w_a_neg ? (~A + 1'b1) : A;
    assign w_b_mag     = w_b_neg ? (~B + 1'b1) : B;
    assign w_div_zero  = op[2] && (B == '0);
    assign w_overflow  = ((w_op == MDOP_DIV) || (w_op == MDOP_REM)) &&
                         (A == {1'b1, {(XLEN-1){1'b0}}}) && (B == '1);
    assign w_special   = w_div_zero || w_overflow;

    // Quotient sign is a^b; remainder sign follows the dividend.
    always_comb begin
        w_sign_nxt = 1'b0;
        case (w_op)
            MDOP_MULH, MDOP_DIV: w_sign_nxt = w_a_neg ^ w_b_neg;
            MDOP_MULHSU, MDOP_REM: w_sign_nxt = w_a_neg;
            default:             w_sign_nxt = 1'b0;
        endcase
    end

    // ---------------- shared step datapath ----------------
    logic            w_is_div;
    logic [XLEN:0]   w_add_a;
    logic [XLEN:0]   w_sum;
    logic            w_carry;

    assign w_is_div = r_op[2];
    // Divide: the 33-bit partial remainder is the stored remainder shifted
    // left with the next dividend bit; the kept value is always < divisor,
    // so the stored remainder fits in XLEN bits.
    assign w_add_a  = w_is_div ? {r_hi, r_lo[XLEN-1]} : {1'b0, r_hi};

    md_addsub #(.W(XLEN + 1)) u_addsub (
        .a     (w_add_a),
        .b     ({1'b0, r_opd}),
        .sub   (w_is_div),
        .sum   (w_sum),
        .carry (w_carry)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= MDS_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = MDS_IDLE;
        end else begin
            case (r_state)
                MDS_IDLE, MDS_DONE: begin
                    if (start)       w_state_nxt = w_special ? MDS_FIX : MDS_CALC;
                    else             w_state_nxt = MDS_IDLE;
                end
                MDS_CALC: if (r_cnt == 6'(MD_STEPS - 1)) w_state_nxt = MDS_FIX;
                MDS_FIX:  w_state_nxt = MDS_DONE;
                default:  w_state_nxt = MDS_IDLE;
            endcase
        end
    end

    // ---------------- operand / iteration registers ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt  <= '0;
            r_op   <= MDOP_MUL;
            r_sign <= 1'b0;
            r_opd  <= '0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
            r_op  <= w_op;
            if (w_special) begin
                // Preloaded so the normal FIX select yields the RV32M value.
                r_sign <= 1'b0;
                r_opd  <= '0;
                r_lo   <= w_div_zero ? '1 : {1'b1, {(XLEN-1){1'b0}}};
                r_hi   <= w_div_zero ? A : '0;
            end else begin
                r_sign <= w_sign_nxt;
                r_hi   <= '0;
                r_opd  <= op[2] ? w_b_mag : w_a_mag;
                r_lo   <= op[2] ? w_a_mag : w_b_mag;
            end
        end else if ((r_state == MDS_CALC) && !flush) begin
            r_cnt <= r_cnt + 6'd1;
            if (w_is_div) begin
                r_hi <= w_carry ? w_sum[XLEN-1:0] : w_add_a[XLEN-1:0];
                r_lo <= {r_lo[XLEN-2:0], w_carry};
            end else if (r_lo[0]) begin
                r_hi <= w_sum[XLEN:1];
                r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
            end else begin
                r_hi <= {1'b0, r_hi[XLEN-1:1]};
                r_lo <= {r_hi[0], r_lo[XLEN-1:1]};
            end
        end
    end

    // ---------------- FIX: sign correction and select ----------------
    logic [XLEN-1:0] w_hi_neg;
    logic [XLEN-1:0] w_fixed;

    // High word of the negated 64-bit product: borrow only when low word is 0.
    assign w_hi_neg = ~r_hi + {{(XLEN-1){1'b0}}, (r_lo == '0)};

    always_comb begin
        w_fixed = r_lo;
        case (r_op)
            MDOP_MUL:                           w_fixed = r_lo;
            MDOP_MULH, MDOP_MULHSU, MDOP_MULHU: w_fixed = r_sign ? w_hi_neg : r_hi;
            MDOP_DIV, MDOP_DIVU:                w_fixed = r_sign ? (~r_lo + 1'b1) : r_lo;
            default:                            w_fixed = r_sign ? (~r_hi + 1'b1) : r_hi;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)                               r_result <= '0;
        else if ((r_state == MDS_FIX) && !flush) r_result <= w_fixed;
    end

    assign busy   = (r_state == MDS_CALC) || (r_state == MDS_FIX);
    assign done   = (r_state == MDS_DONE);
    assign result = r_result;

endmodule : muldiv_seq
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_seq
// Description : Scoreboard bench for muldiv_seq. Stimulus pushes expected
//               results and completion cycles; a negedge monitor pops and
//               compares on every done pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_seq;

    logic        clk   = 1'b0;
    logic        rstn  = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  op    = 3'd0;
    logic [31:0] A     = '0;
    logic [31:0] B     = '0;
    wire         busy;
    wire         done;
    wire  [31:0] result;

    muldiv_seq #(.XLEN(32)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .start  (start),
        .op     (op),
        .A      (A),
        .B      (B),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] res;
        int          due;
        logic [2:0]  op;
    } exp_t;

    exp_t        sbq[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] last_result = '0;

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb, ub, sp;
        logic        [63:0] up;
        int q, r;
        sa = $signed({{32{a[31]}}, a});
        sb = $signed({{32{b[31]}}, b});
        ub = $signed({32'b0, b});
        case (o)
            3'd0: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
            3'd1: begin sp = sa * sb; return sp[63:32]; end
            3'd2: begin sp = sa * ub; return sp[63:32]; end
            3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                q = $signed(a) / $signed(b); return q;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                r = $signed(a) % $signed(b); return r;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        if (o[2] && b == 0) return 2;
        if ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rstn && done) begin
            n_cmp++;
            if (sbq.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_done: cycle %0d result %08h, required no done", cyc, result);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (result !== e.res || cyc != e.due) begin
                    n_bad++;
                    $display("FAIL op%0d_result: got %08h at cycle %0d, required %08h at cycle %0d",
                             e.op, result, cyc, e.res, e.due);
                end
                last_result = result;
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %08h, required %08h", name, act, req);
        end
    endtask

    // Called #1 after a posedge; returns #1 after the accept edge.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] req);
        exp_t e;
        op = o; A = a; B = b; start = 1'b1;
        if (push) begin
            e.res = req; e.due = cyc + latency(o, a, b); e.op = o;
            sbq.push_back(e);
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(output int busy_cnt);
        bit seen;
        seen = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (done) begin
                seen = 1'b1;
            end else begin
                if (busy) busy_cnt++;
                @(posedge clk); #1;
            end
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL done_timeout: no done within 100 cycles, required done");
        end else begin
            check("busy_in_done", {31'b0, busy}, 32'd0);
        end
    endtask

    typedef struct {
        logic [2:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
    } vec_t;

    vec_t vecs[12] = '{
        '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB},
        '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000},
        '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE},
        '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF},
        '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD},
        '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF},
        '{3'd5, 32'd100,        32'd7,         32'd14},
        '{3'd7, 32'd100,        32'd7,         32'd2},
        '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF},
        '{3'd6, 32'd5,          32'd0,         32'd5},
        '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000},
        '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0}
    };

    // ---------------- stimulus ----------------
    initial begin
        int bc;
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        repeat (3) @(posedge clk);
        #1;
        check("reset_busy",   {31'b0, busy}, 32'd0);
        check("reset_done",   {31'b0, done}, 32'd0);
        check("reset_result", result,        32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;

        // Directed vectors; each start lands in the previous op's DONE cycle.
        for (int i = 0; i < 12; i++) begin
            issue(vecs[i].o, vecs[i].a, vecs[i].b, 1'b1, vecs[i].r);
            wait_done(bc);
            if (i == 0) check("mul_busy_cycles", bc, 32'd33);
        end
        @(posedge clk); #1;

        // Flush 10 cycles into a divide.
        issue(3'd4, 32'd1000, 32'd7, 1'b0, 32'd0);
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush_busy",   {31'b0, busy}, 32'd0);
        check("flush_done",   {31'b0, done}, 32'd0);
        check("flush_result", result,        last_result);
        repeat (40) begin @(posedge clk); #1; end
        check("flush_result_held", result, last_result);

        // Flush beats a simultaneous start.
        flush = 1'b1;
        issue(3'd0, 32'd3, 32'd4, 1'b0, 32'd0);
        flush = 1'b0;
        check("flush_beats_start", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;

        // Start while busy is ignored.
        issue(3'd5, 32'd100, 32'd7, 1'b1, 32'd14);
        repeat (5) begin @(posedge clk); #1; end
        op = 3'd0; A = 32'd3; B = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(bc);
        @(posedge clk); #1;

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            case ($urandom_range(0, 9))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 20));
                2:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 1) == 1) begin @(posedge clk); #1; end
            issue(ro, ra, rb, 1'b1, ref_model(ro, ra, rb));
            wait_done(bc);
        end

        // Known non-zero result, then reset in the middle of a multiply.
        @(posedge clk); #1;
        issue(3'd0, 32'd7, 32'd9, 1'b1, 32'd63);
        wait_done(bc);
        @(posedge clk); #1;
        issue(3'd0, 32'd11, 32'd13, 1'b0, 32'd0);
        repeat (5) begin @(posedge clk); #1; end
        #2 rstn = 1'b0;
        #1;
        check("async_reset_busy",   {31'b0, busy}, 32'd0);
        check("async_reset_done",   {31'b0, done}, 32'd0);
        check("async_reset_result", result,        32'd0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (40) begin @(posedge clk); #1; end
        check("post_reset_result", result, 32'd0);

        check("scoreboard_empty", sbq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_muldiv_seq
`default_nettype wire
